hyperbus_mem_responder: RTL and testbench
=========================================

# hyperbus_mem_responder

Responder end of the Hyperbus native memory interface: accepts read/write requests from an initiator such as the Hyperbus FIFO bridge, and serves them from an on-chip word-addressed RAM. It applies a configurable initial latency and a post-transaction recovery period. It sits in the `hbus_clk` domain and stands in for the Hyperbus PHY/controller, both in bench environments and in FPGA builds without external HyperRAM.

## Interface

**Parameters**

- `HBUS_ADDR_WIDTH`, 32: request address width; word (16-bit) address.
- `HBUS_DATA_WIDTH`, 16: beat width.
- `MEM_ADDR_WIDTH`, 10: RAM depth is 2^MEM_ADDR_WIDTH words; only the low bits of the address are used.
- `LATENCY`, 6: cycles from request sample to first data phase; legal range is 1 or more.
- `RECOVERY`, 2: cycles `hbus_busy` is held after a transaction ends; legal range is 0 or more.

**Ports**

- `hbus_clk`, in, 1: the single clock.
- `hbus_rst`, in, 1: reset, synchronous, active-high.
- `hbus_adr_i`, in, HBUS_ADDR_WIDTH: start address; sampled only when a request is accepted.
- `hbus_dat_i`, in, HBUS_DATA_WIDTH: write data from the initiator.
- `hbus_dat_o`, out, HBUS_DATA_WIDTH: read data.
- `hbus_rrq`, in, 1: read request; held high for the whole burst.
- `hbus_wrq`, in, 1: write request; held high for the whole burst.
- `hbus_ready`, out, 1: write data phase active; a beat is captured at each edge where `hbus_ready` and `hbus_wrq` are both high.
- `hbus_valid`, out, 1: `hbus_dat_o` holds a read beat this cycle.
- `hbus_busy`, out, 1: a transaction is in progress or in recovery.

## Operation

- States: IDLE, LAT, READ, WRITE, RECOVER.
- **IDLE**
  - If `hbus_rrq` is high: latch `ptr <= hbus_adr_i[MEM_ADDR_WIDTH-1:0]`, record dir=read, load `lcnt <= LATENCY`, set busy, go to LAT.
  - Else if `hbus_wrq` is high: same, with dir=write.
  - Read wins when both requests are high.
- **LAT**
  - Decrement `lcnt` each edge.
  - If the request for the recorded direction is sampled low: abort, go to RECOVER. No beat is transferred.
  - At the edge where `lcnt` is 1 and the request is still high:
    - Read: `hbus_dat_o <= mem[ptr]`, `hbus_valid <= 1`, `ptr++`, go to READ.
    - Write: `hbus_ready <= 1`, go to WRITE.
- **READ**
  - Each edge with `hbus_rrq` high: `hbus_dat_o <= mem[ptr]`, valid stays 1, `ptr++`.
  - Edge with `hbus_rrq` low: `hbus_valid <= 0`, go to RECOVER.
  - The initiator drops `rrq` registered, so one trailing beat beyond its count is expected; it is harmless.
- **WRITE**
  - Each edge with `hbus_wrq` high: `mem[ptr] <= hbus_dat_i`, `ptr++`.
  - Edge with `hbus_wrq` low: no write, `hbus_ready <= 0`, go to RECOVER.
- **RECOVER**
  - Hold busy for RECOVERY cycles, then clear busy and go to IDLE.
  - If RECOVERY = 0, the RECOVER state is skipped: busy clears on the same edge that leaves READ, WRITE, or LAT.
  - Requests are ignored until IDLE.
- `ptr` wraps modulo 2^MEM_ADDR_WIDTH; bursts have unbounded length.
- RAM is single-port, with synchronous read and write; only one direction is active per transaction.
- RAM contents are not reset and are undefined until written.

## Timing

- Reset values: `hbus_ready`=0, `hbus_valid`=0, `hbus_busy`=0, `hbus_dat_o`=0, state=IDLE.
- Asserting reset mid-transaction forces these values at the next edge. RAM contents are retained, and any write at that edge is suppressed.
- All outputs are registered; there are no combinational paths from input to output.
- `busy` rises on the edge after the request is sampled (edge E0).
- First read beat: valid and data are visible after edge E0+LATENCY, i.e. LATENCY cycles after busy rises.
- First write capture: `ready` is high after edge E0+LATENCY; the first capture happens at edge E0+LATENCY+1 if `wrq` is high.
- Throughput: one beat per cycle.
- Busy falls RECOVERY cycles after the edge that samples the request low.
- The next request is sampled no earlier than the first IDLE cycle after that.

## Test plan

1. **Reset.** Hold `hbus_rst` for 3 cycles with random inputs -> all outputs 0. Assert reset during READ -> `valid`/`busy` are 0 at the next edge; a subsequent read returns prior data.
2. **Write burst.** LATENCY=6; `wrq` with `adr`=0x10; data 0xDEAD, then 0xBEEF on ready; drop `wrq` after 2 captures -> `ready` first high 6 cycles after busy; mem[0x10]=0xDEAD, mem[0x11]=0xBEEF; busy low 2 cycles after `wrq` falls.
3. **Read back.** `rrq` with `adr`=0x10, held for 3 beats -> valid after 6 cycles; data sequence 0xDEAD, 0xBEEF, mem[0x12]; one trailing beat when `rrq` falls.
4. **Wrap.** MEM_ADDR_WIDTH=10; write 0x1111, 0x2222 starting at 0x3FF -> mem[0x3FF]=0x1111, mem[0x000]=0x2222; a read from 0x3FF returns the same pair.
5. **Simultaneous requests.** `rrq` and `wrq` high together in IDLE -> read performed (valid, no ready); RAM unchanged.
6. **Abort.** `rrq` dropped during LAT cycle 3 -> no valid pulse; busy holds RECOVERY cycles after the drop, then IDLE; a new request is accepted next.

Source files
------------

// File: rtl/hyperbus_mem_responder.sv
// hyperbus_mem_responder
//   Responder end of the Hyperbus native memory interface. It accepts read and
//   write bursts from an initiator and serves them from an on-chip, word-addressed
//   single-port RAM. The responder inserts a fixed initial latency before the
//   first data phase and holds busy for a recovery period after each transaction.
//
// Ports
//   hbus_clk    in   single clock
//   hbus_rst    in   synchronous active-high reset
//   hbus_adr_i  in   burst start word address (only the low MEM_ADDR_WIDTH bits are used)
//   hbus_dat_i  in   write beat data
//   hbus_dat_o  out  read beat data (registered)
//   hbus_rrq    in   read request, held high for the whole burst
//   hbus_wrq    in   write request, held high for the whole burst
//   hbus_ready  out  write data phase active; a beat is captured when ready && wrq
//   hbus_valid  out  hbus_dat_o holds a read beat
//   hbus_busy   out  transaction in progress or recovering
module hyperbus_mem_responder #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int LATENCY         = 6,
  parameter int RECOVERY        = 2
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  input  logic                       hbus_rrq,
  input  logic                       hbus_wrq,
  output logic                       hbus_ready,
  output logic                       hbus_valid,
  output logic                       hbus_busy
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int LW    = $clog2(LATENCY + 1);
  localparam int RW    = $clog2(RECOVERY + 2);
  localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY);
  localparam logic [RW-1:0] REC_LOAD = RW'(RECOVERY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAT,
    S_READ,
    S_WRITE,
    S_RECOVER
  } state_t;

  state_t                    state, state_n;
  logic [MEM_ADDR_WIDTH-1:0] ptr, ptr_n;
  logic                      dir_wr, dir_wr_n;
  logic [LW-1:0]             lcnt, lcnt_n;
  logic [RW-1:0]             rcnt, rcnt_n;
  logic                      valid_n, ready_n, busy_n;
  logic                      mem_re, mem_we;
  logic                      finish;
  logic                      req;

  logic [HBUS_DATA_WIDTH-1:0] mem [DEPTH];

  // Upper address bits are deliberately ignored: the RAM aliases modulo its depth.
  if (HBUS_ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_adr_hi
    logic unused_adr_hi;
    assign unused_adr_hi = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  end

  // Request line belonging to the direction recorded at acceptance.
  assign req = dir_wr ? hbus_wrq : hbus_rrq;

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    dir_wr_n = dir_wr;
    lcnt_n   = lcnt;
    rcnt_n   = rcnt;
    valid_n  = hbus_valid;
    ready_n  = hbus_ready;
    busy_n   = hbus_busy;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    finish   = 1'b0;

    case (state)
      S_IDLE: begin
        if (hbus_rrq || hbus_wrq) begin
          ptr_n    = hbus_adr_i[MEM_ADDR_WIDTH-1:0];
          dir_wr_n = !hbus_rrq;  // read wins when both are raised
          lcnt_n   = LAT_LOAD;
          busy_n   = 1'b1;
          state_n  = S_LAT;
        end
      end
      S_LAT: begin
        lcnt_n = lcnt - LW'(1);
        if (!req) begin
          finish = 1'b1;
        end else if (lcnt == LW'(1)) begin
          if (dir_wr) begin
            ready_n = 1'b1;
            state_n = S_WRITE;
          end else begin
            mem_re  = 1'b1;
            valid_n = 1'b1;
            ptr_n   = ptr + MEM_ADDR_WIDTH'(1);
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        if (hbus_rrq) begin
          mem_re = 1'b1;
          ptr_n  = ptr + MEM_ADDR_WIDTH'(1);
        end else begin
          valid_n = 1'b0;
          finish  = 1'b1;
        end
      end
      S_WRITE: begin
        if (hbus_wrq) begin
          mem_we = 1'b1;
          ptr_n  = ptr + MEM_ADDR_WIDTH'(1);
        end else begin
          ready_n = 1'b0;
          finish  = 1'b1;
        end
      end
      S_RECOVER: begin
        if (rcnt <= RW'(1)) begin
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          rcnt_n = rcnt - RW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Common end-of-transaction path for abort, read end and write end.
    // With no recovery period busy clears on the same edge.
    if (finish) begin
      if (RECOVERY == 0) begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end else begin
        rcnt_n  = REC_LOAD;
        state_n = S_RECOVER;
      end
    end
  end

  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      dir_wr     <= 1'b0;
      lcnt       <= '0;
      rcnt       <= '0;
      hbus_valid <= 1'b0;
      hbus_ready <= 1'b0;
      hbus_busy  <= 1'b0;
      hbus_dat_o <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      dir_wr     <= dir_wr_n;
      lcnt       <= lcnt_n;
      rcnt       <= rcnt_n;
      hbus_valid <= valid_n;
      hbus_ready <= ready_n;
      hbus_busy  <= busy_n;
      if (mem_re) begin
        hbus_dat_o <= mem[ptr];
      end
    end
  end

  // RAM is never reset; a write coinciding with reset is dropped.
  always_ff @(posedge hbus_clk) begin
    if (mem_we && !hbus_rst) begin
      mem[ptr] <= hbus_dat_i;
    end
  end

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Scoreboard bench for hyperbus_mem_responder: read beats expected from each
// request are queued when the request is issued; a monitor pops and compares
// whenever hbus_valid is high. Timing of ready/valid/busy is checked inline.
module tb_hyperbus_mem_responder;

  localparam int LAT = 6;
  localparam int REC = 2;

  logic        hbus_clk = 1'b0;
  logic        hbus_rst = 1'b1;
  logic [31:0] hbus_adr_i = '0;
  logic [15:0] hbus_dat_i = '0;
  logic [15:0] hbus_dat_o;
  logic        hbus_rrq = 1'b0;
  logic        hbus_wrq = 1'b0;
  logic        hbus_ready;
  logic        hbus_valid;
  logic        hbus_busy;

  int total  = 0;
  int passed = 0;

  logic [15:0] expq[$];
  logic [15:0] tbmem [1024];

  always #5 hbus_clk = ~hbus_clk;

  hyperbus_mem_responder #(
    .HBUS_ADDR_WIDTH(32),
    .HBUS_DATA_WIDTH(16),
    .MEM_ADDR_WIDTH (10),
    .LATENCY        (LAT),
    .RECOVERY       (REC)
  ) dut (
    .hbus_clk  (hbus_clk),
    .hbus_rst  (hbus_rst),
    .hbus_adr_i(hbus_adr_i),
    .hbus_dat_i(hbus_dat_i),
    .hbus_dat_o(hbus_dat_o),
    .hbus_rrq  (hbus_rrq),
    .hbus_wrq  (hbus_wrq),
    .hbus_ready(hbus_ready),
    .hbus_valid(hbus_valid),
    .hbus_busy (hbus_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(negedge hbus_clk);
  endtask

  // Monitor: every read beat the DUT presents must match the next queued value.
  always @(negedge hbus_clk) begin
    if (hbus_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got data %h with no beat expected at %0t",
                 hbus_dat_o, $time);
      end else begin
        chk("rd_data", 32'(hbus_dat_o), 32'(expq.pop_front()));
      end
    end
  end

  // Steps until busy drops (bounded); the count must equal the recovery period.
  task automatic wait_busy_fall(input string nm);
    int r = 0;
    while (hbus_busy === 1'b1 && r < 20) begin
      step();
      r++;
    end
    chk(nm, 32'(r), 32'(REC));
  endtask

  task automatic do_write(input logic [9:0] a, input logic [15:0] d0, input logic [15:0] d1);
    hbus_adr_i = {22'h2AAAAA, a};
    hbus_wrq   = 1'b1;
    hbus_dat_i = d0;
    step();                       // after E0
    chk("wr_busy_rise", 32'(hbus_busy), 32'd1);
    repeat (LAT - 1) step();      // after E0+LAT-1
    chk("wr_ready_early", 32'(hbus_ready), 32'd0);
    step();                       // after E0+LAT
    chk("wr_ready_first", 32'(hbus_ready), 32'd1);
    step();                       // d0 captured
    hbus_dat_i = d1;
    step();                       // d1 captured
    hbus_wrq   = 1'b0;
    hbus_dat_i = 16'h0BAD;
    step();                       // wrq sampled low
    chk("wr_ready_drop", 32'(hbus_ready), 32'd0);
    wait_busy_fall("wr_busy_fall");
    tbmem[a]           = d0;
    tbmem[10'(a + 1)]  = d1;
  endtask

  // Holds rrq for n beats after the first, giving n+1 beats including the trailing one.
  task automatic do_read(input logic [9:0] a, input int unsigned n, input logic with_wrq);
    for (int unsigned j = 0; j <= n; j++) expq.push_back(tbmem[10'(32'(a) + j)]);
    hbus_adr_i = {22'h155555, a};
    hbus_rrq   = 1'b1;
    hbus_wrq   = with_wrq;
    hbus_dat_i = 16'hFFFF;
    step();
    chk("rd_busy_rise", 32'(hbus_busy), 32'd1);
    repeat (LAT - 1) step();
    chk("rd_valid_early", 32'(hbus_valid), 32'd0);
    step();
    chk("rd_valid_first", 32'(hbus_valid), 32'd1);
    chk("rd_no_ready", 32'(hbus_ready), 32'd0);
    repeat (n) step();
    hbus_rrq = 1'b0;
    hbus_wrq = 1'b0;
    step();
    chk("rd_valid_drop", 32'(hbus_valid), 32'd0);
    wait_busy_fall("rd_busy_fall");
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      hbus_rrq   = 1'($urandom_range(0, 1));
      hbus_wrq   = 1'($urandom_range(0, 1));
      hbus_adr_i = $urandom;
      hbus_dat_i = 16'($urandom);
      step();
      chk("rst_valid", 32'(hbus_valid), 32'd0);
      chk("rst_ready", 32'(hbus_ready), 32'd0);
      chk("rst_busy",  32'(hbus_busy),  32'd0);
      chk("rst_dat",   32'(hbus_dat_o), 32'd0);
    end
    hbus_rst = 1'b0;
    hbus_rrq = 1'b0;
    hbus_wrq = 1'b0;
    step();

    // Write bursts, then read back with trailing beat
    do_write(10'h012, 16'h1234, 16'h5678);
    do_write(10'h010, 16'hDEAD, 16'hBEEF);
    do_read(10'h010, 2, 1'b0);    // DEAD, BEEF, trailing 1234

    // Address wrap
    do_write(10'h3FF, 16'h1111, 16'h2222);
    do_read(10'h3FF, 1, 1'b0);    // 1111, 2222

    // Simultaneous requests: read wins, RAM untouched
    do_read(10'h010, 1, 1'b1);
    do_read(10'h010, 3, 1'b0);    // DEAD, BEEF, 1234, 5678

    // Abort during latency: rrq sampled low at E0+3
    hbus_adr_i = 32'h0000_0010;
    hbus_rrq   = 1'b1;
    step();
    chk("ab_busy_rise", 32'(hbus_busy), 32'd1);
    step();
    step();
    hbus_rrq = 1'b0;
    step();
    chk("ab_no_valid", 32'(hbus_valid), 32'd0);
    wait_busy_fall("ab_busy_fall");
    do_read(10'h3FF, 1, 1'b0);    // new request accepted right after abort

    // Reset during READ: only the first beat is seen
    expq.push_back(tbmem[10'h010]);
    hbus_adr_i = 32'h0000_0010;
    hbus_rrq   = 1'b1;
    repeat (LAT + 1) step();      // first beat visible
    hbus_rst = 1'b1;
    hbus_rrq = 1'b0;
    step();
    chk("mid_rst_valid", 32'(hbus_valid), 32'd0);
    chk("mid_rst_busy",  32'(hbus_busy),  32'd0);
    chk("mid_rst_ready", 32'(hbus_ready), 32'd0);
    chk("mid_rst_dat",   32'(hbus_dat_o), 32'd0);
    hbus_rst = 1'b0;
    step();
    do_read(10'h010, 1, 1'b0);    // DEAD, BEEF retained

    repeat (5) step();
    chk("sb_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
